// File: rtl/adc_fifo_sched.sv
// Per-channel sample hold registers feeding one FIFO write port through a round-robin arbiter.
// Latency: strobe -> pending next cycle -> write request the cycle after; FIFO full holds the output word, and a channel that is still pending overwrites and counts the drop.
module adc_fifo_sched #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 12,
    parameter int CH_WIDTH   = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              smp_stb_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   smp_data_i,
    input  logic                           clr_i,
    output logic [CH_WIDTH+DATA_WIDTH-1:0] fifo_wr_data_o,
    output logic                           fifo_wr_en_o,
    input  logic                           fifo_full_i,
    output logic [NUM_CH-1:0]              pending_o,
    output logic [NUM_CH-1:0]              overflow_o,
    output logic [NUM_CH*CNT_WIDTH-1:0]    drop_cnt_o,
    output logic                           busy_o
);

    typedef struct packed {
        logic [CH_WIDTH-1:0]   ch;
        logic [DATA_WIDTH-1:0] dat;
    } word_t;

    logic [NUM_CH-1:0]     hold_vld;
    logic [DATA_WIDTH-1:0] hold_dat [NUM_CH];
    logic                  out_vld;
    word_t                 out_word;
    logic [CH_WIDTH-1:0]   rr_ptr;
    logic [CH_WIDTH-1:0]   gnt_idx;
    logic                  gnt_found;
    logic                  gnt_ok;
    logic                  gnt_vld;
    logic [NUM_CH-1:0]     gnt_oh;
    logic [NUM_CH-1:0]     drop;
    logic [CNT_WIDTH-1:0]  drop_cnt [NUM_CH];
    logic [NUM_CH-1:0]     ovf;
    logic [CH_WIDTH:0]     cand;

    // The output slot can take a new word when it is empty or is being drained this cycle.
    assign gnt_ok = !out_vld || !fifo_full_i;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = {1'b0, rr_ptr} + (CH_WIDTH+1)'(i);
            if (cand >= (CH_WIDTH+1)'(NUM_CH)) begin
                cand = cand - (CH_WIDTH+1)'(NUM_CH);
            end
            if (!gnt_found && hold_vld[cand[CH_WIDTH-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[CH_WIDTH-1:0];
            end
        end
    end

    assign gnt_vld = gnt_ok && gnt_found;

    always_comb begin
        gnt_oh = '0;
        drop   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            gnt_oh[k] = gnt_vld && (gnt_idx == CH_WIDTH'(k));
            drop[k]   = smp_stb_i[k] && hold_vld[k] && !gnt_oh[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                hold_vld[k] <= 1'b0;
                hold_dat[k] <= '0;
                drop_cnt[k] <= '0;
                ovf[k]      <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (smp_stb_i[k]) begin
                    hold_vld[k] <= 1'b1;
                    hold_dat[k] <= smp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                end else if (gnt_oh[k]) begin
                    hold_vld[k] <= 1'b0;
                end
                // A drop coinciding with clear still leaves a record of that drop.
                if (clr_i) begin
                    drop_cnt[k] <= drop[k] ? CNT_WIDTH'(1) : '0;
                    ovf[k]      <= drop[k];
                end else if (drop[k]) begin
                    if (drop_cnt[k] != {CNT_WIDTH{1'b1}}) begin
                        drop_cnt[k] <= drop_cnt[k] + CNT_WIDTH'(1);
                    end
                    ovf[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_word <= '0;
            rr_ptr   <= CH_WIDTH'(NUM_CH-1);
        end else if (gnt_vld) begin
            out_vld      <= 1'b1;
            out_word.ch  <= gnt_idx;
            out_word.dat <= hold_dat[gnt_idx];
            rr_ptr       <= gnt_idx;
        end else if (out_vld && !fifo_full_i) begin
            out_vld <= 1'b0;
        end
    end

    always_comb begin
        drop_cnt_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            drop_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = drop_cnt[k];
        end
    end

    assign fifo_wr_data_o = out_word;
    assign fifo_wr_en_o   = out_vld;
    assign pending_o      = hold_vld;
    assign overflow_o     = ovf;
    assign busy_o         = (|hold_vld) || out_vld;

endmodule

// File: doc/adc_fifo_sched.md
# adc_fifo_sched

Multi-channel sample scheduler that feeds the single-clock sample FIFO from several SAR ADC conversion channels. Each channel delivers a one-cycle sample strobe that cannot be stalled. The block buffers one sample per channel and shares the FIFO write port between channels with round-robin arbitration. It honours the FIFO full flag through a held output register, tags each word with its channel number, and counts samples lost to overrun.

## Interface
- NUM_CH, 4: number of sample channels, 2..16.
- DATA_WIDTH, 12: sample width in bits.
- CH_WIDTH, 2: channel tag width; must satisfy 2^CH_WIDTH >= NUM_CH.
- CNT_WIDTH, 8: width of each per-channel drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- smp_stb_i  in  NUM_CH  per-channel one-cycle strobe, "sample valid".
- smp_data_i  in  NUM_CH*DATA_WIDTH  channel k at [k*DATA_WIDTH +: DATA_WIDTH]; sampled when its strobe is high.
- clr_i  in  1  clears drop counters and overflow flags.
- fifo_wr_data_o  out  CH_WIDTH+DATA_WIDTH  {channel, sample}; connects to FIFO wr_data_i.
- fifo_wr_en_o  out  1  write request; connects to FIFO wr_en_i.
- fifo_full_i  in  1  FIFO full_o.
- pending_o  out  NUM_CH  per-channel hold register occupied.
- overflow_o  out  NUM_CH  sticky: channel lost at least one sample.
- drop_cnt_o  out  NUM_CH*CNT_WIDTH  per-channel saturating drop count, channel k at [k*CNT_WIDTH +: CNT_WIDTH].
- busy_o  out  1  any pending_o bit set, or fifo_wr_en_o set.

## Operation
- **Hold stage.** One register plus a valid bit per channel.
  - A strobe loads the data and sets valid.
  - A grant clears valid, unless a strobe arrives in the same cycle; then the new data loads and valid stays 1 (no drop).
- **Overrun.** A strobe while valid=1 and the channel is not granted that cycle:
  - the new sample overwrites the old one (newest kept);
  - drop_cnt increments, saturating at all-ones;
  - overflow_o for that channel sets.
- **Output stage.** One register, out_valid = fifo_wr_en_o.
  - The FIFO accepts a word in any cycle where fifo_wr_en_o=1 and fifo_full_i=0.
  - When fifo_full_i=1, data and enable hold unchanged.
- **Grant condition.** A grant is allowed when out_valid=0, or out_valid=1 and fifo_full_i=0.
  - At most one grant per cycle.
  - The granted {ch, data} loads the output register at the clock edge.
- **Round-robin.** A pointer holds the last granted channel.
  - Search order: ptr+1, ptr+2, ... wrapping modulo NUM_CH, ending at ptr.
  - The pointer updates only on a grant.
  - Reset value is NUM_CH-1, so channel 0 has first priority.
- **Clear.** clr_i zeroes all counters and overflow flags.
  - If a drop occurs in the same cycle, the result is count=1 and flag=1.
- **Reset.**
  - All hold valid bits, the output register, the pointer, counters and flags clear.
  - Pending and in-flight samples are discarded; this is the required behaviour for reset mid-operation.
  - Strobes in reset cycles are ignored.

## Timing
- Reset values: fifo_wr_en_o=0, fifo_wr_data_o=0, pending_o=0, overflow_o=0, drop_cnt_o=0, busy_o=0.
- Latency, strobe in cycle t with no contention and FIFO not full:
  - pending set in t+1;
  - fifo_wr_en_o high in t+2, for exactly one cycle.
- Throughput: one FIFO write per cycle while samples are pending and fifo_full_i=0.
- Outputs are driven directly from registers.
- Grant logic is combinational from hold valid bits, out_valid and fifo_full_i.
- No combinational path from smp_stb_i to any output.
- Unused channel tag codes (>= NUM_CH) are never emitted.

## Test plan
- **Reset and single sample.** Reset, then strobe ch2 with 0x5A5 in cycle t -> all outputs 0 during reset; fifo_wr_en_o=1 only in t+2; data = {2'd2, 12'h5A5}.
- **Fairness.** Strobe all four channels together with 0x100..0x103 -> four back-to-back writes in order ch0, ch1, ch2, ch3. Then strobe ch3 and ch1 together -> order ch1, ch3.
- **Backpressure.** fifo_full_i=1 for 5 cycles while fifo_wr_en_o=1 -> data and enable stable throughout; word accepted on the first cycle full=0; drop counts stay 0.
- **Overrun.** fifo_full_i=1 throughout; strobe ch0 with 0x001, 0x002, 0x003 at cycles 0, 3, 5; release full at cycle 8 -> writes 0x001 then 0x003; drop_cnt[0]=1; overflow_o[0]=1.
- **Saturation and clear.** 300 overrun events on ch1 with CNT_WIDTH=8 -> count 255. clr_i -> count 0, flag 0. clr_i coincident with a drop -> count 1.
- **Reset mid-operation.** rst with all channels pending and the output valid -> next cycle pending_o=0, fifo_wr_en_o=0, pointer restarts at ch0 priority.
